// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One digit is driven per refresh slot; new display words are held in
// a shadow register and committed only at frame boundaries so a frame never
// shows a mix of old and new digits.
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_WIDTH   = 17,
  parameter int GUARD       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lzb_en,
  output logic [3:0]              nib,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WORD_W = 4 * NUM_DIGITS;

  // State registers
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [WORD_W-1:0]     r_disp;
  logic [WORD_W-1:0]     r_shadow;
  logic                  r_pending;
  logic [3:0]            r_nib;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_start;

  // Next-state values
  logic                  w_tick;
  logic                  w_last_digit;
  logic                  w_wrap;
  logic [DIV_WIDTH-1:0]  w_div_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [WORD_W-1:0]     w_disp_nxt;
  logic [WORD_W-1:0]     w_shadow_nxt;
  logic                  w_pending_nxt;
  logic                  w_past_guard;

  // Digit selection / blanking of the post-edge digit
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic [3:0]            w_nib_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  // Slot timing, frame wrap and double-buffer commit decisions
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the block leaves it unassigned, which would infer a latch.
    w_tick        = (r_div_cnt == DIV_WIDTH'(REFRESH_DIV - 1));
    w_last_digit  = (r_idx == IDX_W'(NUM_DIGITS - 1));
    w_wrap        = w_tick && w_last_digit;
    w_div_nxt     = w_tick ? '0 : r_div_cnt + 1'b1;
    w_idx_nxt     = r_idx;
    w_disp_nxt    = r_disp;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;

    if (w_tick) begin
      w_idx_nxt = w_last_digit ? '0 : r_idx + 1'b1;
    end

    if (load) begin
      w_shadow_nxt = value;
    end

    if (w_wrap) begin
      // A load on the wrap edge bypasses the shadow and is shown this frame.
      if (load) begin
        w_disp_nxt = value;
      end else if (r_pending) begin
        w_disp_nxt = r_shadow;
      end
      w_pending_nxt = 1'b0;
    end else if (load) begin
      w_pending_nxt = 1'b1;
    end

    w_past_guard = (w_div_nxt >= DIV_WIDTH'(GUARD));
  end

  // Pick the nibble and anode pattern for the digit that will be active after the edge
  always_comb begin
    w_zero_run = 1'b1;
    w_lz_blank = '0;
    w_nib_nxt  = '0;
    w_an_nxt   = '1;

    // Digit i (i>0) is leading-zero when it and every digit above it are zero.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run    = w_zero_run && (w_disp_nxt[4*i +: 4] == 4'h0);
      w_lz_blank[i] = w_zero_run;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib_nxt = w_disp_nxt[4*i +: 4];
        w_an_nxt[i] = ~(w_past_guard && !blank_mask[i] && !(lzb_en && w_lz_blank[i]));
      end
    end
  end

  // Register all state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_idx         <= '0;
      r_disp        <= '0;
      r_shadow      <= '0;
      r_pending     <= 1'b0;
      r_nib         <= 4'h0;
      r_an          <= '1;
      r_frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      r_div_cnt     <= w_div_nxt;
      r_idx         <= w_idx_nxt;
      r_disp        <= w_disp_nxt;
      r_shadow      <= w_shadow_nxt;
      r_pending     <= w_pending_nxt;
      r_nib         <= w_nib_nxt;
      r_an          <= w_an_nxt;
      r_frame_start <= w_wrap;
    end
  end

  assign nib         = r_nib;
  assign an          = r_an;
  assign frame_start = r_frame_start;
  assign pending     = r_pending;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: a cycle-level reference model derived
// from elapsed time pushes the expected outputs into a queue every edge, and a
// monitor pops and compares them half a cycle later.
module tb_seg_scan_mux;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int G     = 2;
  localparam int FRAME = N * R;

  typedef struct packed {
    logic [3:0]   nib;
    logic [N-1:0] an;
    logic         fs;
    logic         pend;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0]   blank_mask = '0;
  logic           lzb_en = 1'b0;
  logic [3:0]     nib;
  logic [N-1:0]   an;
  logic           frame_start;
  logic           pending;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q[$];

  // Reference model state: elapsed cycles since reset plus the abstract buffers.
  int             m_t = 0;
  logic [4*N-1:0] m_disp = '0;
  logic [4*N-1:0] m_shadow = '0;
  logic           m_pend = 1'b0;

  seg_scan_mux #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .DIV_WIDTH  (4),
    .GUARD      (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .lzb_en     (lzb_en),
    .nib        (nib),
    .an         (an),
    .frame_start(frame_start),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
  endtask

  // Reference model: position in the scan is plain arithmetic on elapsed cycles.
  always @(posedge clk) begin
    exp_t e;
    int   div, idx;
    bit   wrap, dark;
    if (!rst_n) begin
      m_t      = 0;
      m_disp   = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      e        = '{nib: 4'h0, an: '1, fs: 1'b0, pend: 1'b0};
    end else begin
      m_t  = m_t + 1;
      div  = m_t % R;
      idx  = (m_t / R) % N;
      wrap = (m_t % FRAME) == 0;
      if (wrap) begin
        if (load) m_disp = value;
        else if (m_pend) m_disp = m_shadow;
        if (load) m_shadow = value;
        m_pend = 1'b0;
      end else if (load) begin
        m_shadow = value;
        m_pend   = 1'b1;
      end
      dark = blank_mask[idx] || (lzb_en && idx > 0 && (m_disp >> (4 * idx)) == 0);
      e.nib  = 4'((m_disp >> (4 * idx)) & 16'h000F);
      e.an   = '1;
      if (div >= G && !dark) e.an[idx] = 1'b0;
      e.fs   = wrap;
      e.pend = m_pend;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs against the oldest expectation, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scan{nib,an,fs,pend}", {nib, an, frame_start, pending}, e);
    end
  end

  // Advance to the negedge whose preceding posedge left the model at frame phase ph.
  task automatic wait_phase(input int ph);
    int k = 0;
    while ((m_t % FRAME) != ph && k < 3 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check("wait_phase_timeout", 32'(k < 3 * FRAME), 32'd1);
  endtask

  task automatic pulse_load(input logic [4*N-1:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2 * FRAME + 4);

    // Mid-frame load: stays pending until the wrap, then appears on digit 0.
    wait_phase(R + 3);
    pulse_load(16'h1234);
    check("load1234_pending", 32'(pending), 32'd1);
    check("load1234_nib_unchanged", 32'(nib), 32'd0);
    wait_phase(0);
    check("load1234_commit_pending", 32'(pending), 32'd0);
    check("load1234_commit_nib", 32'(nib), 32'h4);
    idle(FRAME);

    // Two loads in one frame: the last one wins.
    wait_phase(2);
    pulse_load(16'hAAAA);
    wait_phase(20);
    pulse_load(16'h5555);
    wait_phase(0);
    check("last_load_wins_nib", 32'(nib), 32'h5);
    idle(FRAME);

    // Load on the exact wrap edge: shown immediately, never pending.
    wait_phase(FRAME - 1);
    pulse_load(16'h0007);
    check("wrap_load_nib", 32'(nib), 32'h7);
    check("wrap_load_pending", 32'(pending), 32'd0);
    idle(FRAME + 3);

    // Leading-zero blanking.
    lzb_en = 1'b1;
    pulse_load(16'h0040);
    idle(2 * FRAME);
    pulse_load(16'h0000);
    idle(2 * FRAME);
    lzb_en = 1'b0;

    // Randomised traffic.
    for (int c = 0; c < 800; c++) begin
      load       = ($urandom_range(0, 9) == 0);
      value      = 16'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      lzb_en     = 1'($urandom);
      @(negedge clk);
    end
    load       = 1'b0;
    lzb_en     = 1'b0;
    blank_mask = 4'b0100;
    pulse_load(16'hFFFF);
    idle(2 * FRAME);

    // Asynchronous reset mid-slot with digit 2 masked.
    wait_phase(3 * R + 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_an", 32'(an), 32'hF);
    check("async_reset_nib", 32'(nib), 32'h0);
    check("async_reset_pending", 32'(pending), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2 * FRAME + 2);

    check("enough_scan_checks", 32'(n_checks > 1000), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Holds a NUM_DIGITS x 4-bit display word and selects one digit per refresh slot.
- Drives that digit's nibble to the downstream single-digit segment decoder (nib[3:0] -> x3..x0) and its active-low anode enable.
- New values are double-buffered and applied only at frame boundaries, so the display never tears; leading-zero and per-digit blanking are also supported.

Parameters:
- NUM_DIGITS, 4, digits scanned per frame (2..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (>= GUARD+2).
- DIV_WIDTH, 17, width of slot counter (2^DIV_WIDTH >= REFRESH_DIV).
- GUARD, 4, cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe: capture value into shadow register.
- value  in  4*NUM_DIGITS  digit nibbles; [3:0] = digit 0 (least significant, rightmost).
- blank_mask  in  NUM_DIGITS  bit i=1 forces digit i dark.
- lzb_en  in  1  leading-zero blanking enable.
- nib  out  4  nibble of current digit, to segment decoder.
- an  out  NUM_DIGITS  anode enables, active-low, at most one bit low.
- frame_start  out  1  one-cycle pulse on the edge where idx wraps to 0.
- pending  out  1  shadow holds a value not yet displayed.

Behaviour:
- Reset (async, rst_n=0): div_cnt=0, idx=0, disp_reg=0, shadow=0, pending=0, nib=0, an=all 1s, frame_start=0. Release takes effect on the next rising edge with normal counting from 0.
- div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- The edge where div_cnt is REFRESH_DIV-1 is a "tick".
- On a tick, idx advances; NUM_DIGITS-1 wraps to 0. That wrap is a "frame wrap".
- Frame wrap:
  - frame_start=1 for that one cycle only.
  - If pending=1, disp_reg<=shadow and pending<=0.
- load with no frame wrap on the same edge: shadow<=value, pending<=1. A later load overwrites an earlier one; last value wins.
- load on the same edge as a frame wrap: disp_reg<=value directly, pending<=0, shadow<=value.
- nib and an are registered and reflect the post-edge idx and disp_reg. Digit 0 of a new frame already shows the newly committed value.
- nib = disp_reg[4*idx+3:4*idx], regardless of blanking.
- an[idx]=0 only if all hold:
  - post-edge div_cnt >= GUARD;
  - blank_mask[idx]=0;
  - digit idx is not leading-zero blanked.
  All other an bits are 1.
- Leading-zero blanking: digit i (i>0) is blanked when lzb_en=1 and disp_reg digits NUM_DIGITS-1 down to i are all zero. Digit 0 is never LZ-blanked, so a value of 0 shows a single "0".
- blank_mask and lzb_en are sampled every cycle and are not buffered.
- load has no handshake back-pressure and is always accepted.
- Latency: a load at least one cycle before a frame wrap is visible on digit 0 at that wrap. Worst case is one frame, NUM_DIGITS*REFRESH_DIV cycles.

Test Plan (REFRESH_DIV=8, GUARD=2, NUM_DIGITS=4):
- Reset then idle → an=4'b1111 for cycles 0-1 and an=4'b1110 for cycles 2-7; idx then steps 1,2,3,0. frame_start pulses every 32 cycles; nib=0.
- load value=16'h1234 mid-frame at idx=1 → pending=1, nib unchanged until the wrap. At the wrap, pending=0 and slots 0..3 show nib=4,3,2,1.
- load 16'hAAAA then 16'h5555 in the same frame → only 5555 is displayed; no frame ever shows mixed digits.
- load 16'h0007 on the exact frame-wrap edge → digit 0 shows 7 in that same frame, pending stays 0.
- lzb_en=1, value=16'h0040 → digits 3 and 2 keep an high; digit 1 (nib=4) and digit 0 (nib=0) are lit. value=0 → only digit 0 lit.
- blank_mask=4'b0100 plus rst_n asserted mid-slot → digit 2 is never lit. On reset, an=1111 immediately (async) and disp_reg=0; after release the scan restarts at idx=0, div_cnt=0.
